// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore FSM control unit for the multicycle CPU. It decodes the opcode
//   held in IR[31:26] and sequences FETCH / DECODE / execute / memory /
//   writeback, driving every Datapath control input. It also provides
//   run/halt at instruction boundaries and a retired-instruction counter.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   run           1 = execute; sampled in IDLE and in each last state
//   opcode        IR[31:26], stable from DECODE to end of instruction
//   SelectIns     memory address mux (1 = PC, 0 = ALUOut)
//   IRWrite       instruction register load
//   PCWrite       unconditional PC write
//   BEQ           conditional PC write (gated by ALU zero in Datapath)
//   PCSrc         00 ALU result, 01 ALUOut, 10 jump target
//   RegWrite      register file write enable
//   RegDst        1 = rd, 0 = rt
//   MemtoReg      1 = memory data register, 0 = ALUOut
//   MemWrite      data memory write enable
//   ALUSrcA       0 = PC, 1 = register A
//   ALUSrcB       00 reg B, 01 const 1, 10 sign-ext imm, 11 branch offset
//   ALUOp         00 add, 01 sub, 10 funct-decoded
//   illegal       high in DECODE when the opcode is unrecognised
//   instr_done    high in the last cycle of every legal instruction
//   instr_count   retired legal instructions, wraps modulo 2^CNT_W
//   state_out     current state encoding (debug)

module multicycle_control #(
    parameter int unsigned CNT_W   = 16,
    parameter logic [5:0]  OP_R    = 6'b000000,
    parameter logic [5:0]  OP_ADDI = 6'b001000,
    parameter logic [5:0]  OP_LW   = 6'b100011,
    parameter logic [5:0]  OP_SW   = 6'b101011,
    parameter logic [5:0]  OP_BEQ  = 6'b000100,
    parameter logic [5:0]  OP_J    = 6'b000010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    output logic             SelectIns,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             BEQ,
    output logic [1:0]       PCSrc,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_out
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC_R   = 4'd7;
    localparam logic [3:0] S_WB_R     = 4'd8;
    localparam logic [3:0] S_EXEC_I   = 4'd9;
    localparam logic [3:0] S_WB_I     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             legal_op_c;
    logic             last_c;

    assign legal_op_c = (opcode == OP_R)   || (opcode == OP_ADDI) ||
                        (opcode == OP_LW)  || (opcode == OP_SW)   ||
                        (opcode == OP_BEQ) || (opcode == OP_J);

    assign last_c = (state_q == S_MEM_WB) || (state_q == S_MEM_WR) ||
                    (state_q == S_WB_R)   || (state_q == S_WB_I)   ||
                    (state_q == S_BRANCH) || (state_q == S_JUMP);

    // State and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; counter steps on the edge leaving a last state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if      (opcode == OP_R)                      state_d = S_EXEC_R;
                else if (opcode == OP_ADDI)                   state_d = S_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                    state_d = S_BRANCH;
                else if (opcode == OP_J)                      state_d = S_JUMP;
                else                                          state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_WB, S_MEM_WR, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
                state_d = run ? S_FETCH : S_IDLE;
                count_d = count_q + CNT_W'(1);
            end
            default:    state_d = S_IDLE;  // unused encodings recover to IDLE
        endcase
    end

    // Moore output decode; write strobes are suppressed while rst is high.
    always_comb begin
        SelectIns  = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        BEQ        = 1'b0;
        PCSrc      = 2'b00;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        illegal    = 1'b0;
        instr_done = last_c;
        case (state_q)
            S_FETCH: begin
                SelectIns = 1'b1;
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;  // precompute branch target into ALUOut
                illegal = ~legal_op_c;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: MemWrite = 1'b1;
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_WB_I: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                BEQ     = 1'b1;
                PCSrc   = 2'b01;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: ;
        endcase
        if (rst) begin
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            PCWrite  = 1'b0;
            BEQ      = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    assign instr_count = count_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and randomized instruction streams
// checked against a per-instruction reference of state paths and controls.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [5:0] opcode;

    logic        SelectIns, IRWrite, PCWrite, BEQ, RegWrite, RegDst, MemtoReg, MemWrite, ALUSrcA;
    logic        illegal, instr_done;
    logic [1:0]  PCSrc, ALUSrcB, ALUOp;
    logic [15:0] instr_count;
    logic [3:0]  state_out;

    logic        b_sel, b_irw, b_pcw, b_beq, b_rw, b_rd, b_m2r, b_mw, b_asa, b_ill, b_done;
    logic [1:0]  b_pcs, b_asb, b_aop;
    logic [1:0]  b_count;
    logic [3:0]  b_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt      = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .SelectIns(SelectIns), .IRWrite(IRWrite), .PCWrite(PCWrite), .BEQ(BEQ),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal(illegal), .instr_done(instr_done), .instr_count(instr_count),
        .state_out(state_out)
    );

    // Narrow-counter instance sharing the same stimulus, for wrap checking.
    multicycle_control #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .SelectIns(b_sel), .IRWrite(b_irw), .PCWrite(b_pcw), .BEQ(b_beq),
        .PCSrc(b_pcs), .RegWrite(b_rw), .RegDst(b_rd), .MemtoReg(b_m2r),
        .MemWrite(b_mw), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ALUOp(b_aop),
        .illegal(b_ill), .instr_done(b_done), .instr_count(b_count),
        .state_out(b_state)
    );

    logic [16:0] act;
    assign act = {SelectIns, IRWrite, PCWrite, BEQ, PCSrc, RegWrite, RegDst,
                  MemtoReg, MemWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, instr_done};

    function automatic bit is_legal(logic [5:0] op);
        return op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J;
    endfunction

    // Cycles from FETCH to last state inclusive.
    function automatic int path_len(logic [5:0] op);
        if (op == OP_R || op == OP_ADDI || op == OP_SW) return 4;
        if (op == OP_LW)                                return 5;
        if (op == OP_BEQ || op == OP_J)                 return 3;
        return 2;
    endfunction

    // State visited in cycle k of an instruction with opcode op.
    function automatic int path_st(logic [5:0] op, int k);
        if (k == 0) return 1;
        if (k == 1) return 2;
        if (op == OP_R)    return (k == 2) ? 7 : 8;
        if (op == OP_ADDI) return (k == 2) ? 9 : 10;
        if (op == OP_LW)   return k + 1;
        if (op == OP_SW)   return (k == 2) ? 3 : 6;
        if (op == OP_BEQ)  return 11;
        return 12;
    endfunction

    // Control vector expected while sitting in state s.
    function automatic logic [16:0] exp_ctrl(int s, logic [5:0] op);
        logic sel, irw, pcw, beq, rw, rd, m2r, mw, asa, ill, done;
        logic [1:0] pcs, asb, aop;
        sel = 0; irw = 0; pcw = 0; beq = 0; rw = 0; rd = 0; m2r = 0; mw = 0;
        asa = 0; ill = 0; done = 0; pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (s)
            1:  begin sel = 1; irw = 1; pcw = 1; asb = 2'b01; end
            2:  begin asb = 2'b11; ill = !is_legal(op); end
            3:  begin asa = 1; asb = 2'b10; end
            5:  begin rw = 1; m2r = 1; done = 1; end
            6:  begin mw = 1; done = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; done = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: begin rw = 1; done = 1; end
            11: begin asa = 1; aop = 2'b01; beq = 1; pcs = 2'b01; done = 1; end
            12: begin pcw = 1; pcs = 2'b10; done = 1; end
            default: ;
        endcase
        return {sel, irw, pcw, beq, pcs, rw, rd, m2r, mw, asa, asb, aop, ill, done};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(int s, logic [5:0] op);
        chk($sformatf("state@%0d", s), 32'(state_out), 32'(s));
        chk($sformatf("ctrl@s%0d", s), 32'(act), 32'(exp_ctrl(s, op)));
        chk($sformatf("count@s%0d", s), 32'(instr_count), 32'(cnt % 65536));
        chk($sformatf("count2@s%0d", s), 32'(b_count), 32'(cnt % 4));
    endtask

    // Runs one instruction starting in FETCH. run_mid: 0/1 forced, 2 random.
    task automatic do_instr(logic [5:0] op, int run_mid, bit run_end);
        int n;
        n = path_len(op);
        opcode = op;
        for (int k = 0; k < n; k++) begin
            check_cycle(path_st(op, k), op);
            if (k == n - 1)    run = run_end;
            else if (run_mid == 2) run = 1'($urandom_range(0, 1));
            else               run = 1'(run_mid);
            tick();
        end
        if (is_legal(op)) cnt++;
        if (is_legal(op) && !run_end) begin
            check_cycle(0, op);
            run = 1'b0;
            tick();
            check_cycle(0, op);
            run = 1'b1;
            tick();
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal_ops [6];
        legal_ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};

        // Reset held for three cycles, then IDLE holds with run=0.
        rst = 1'b1; run = 1'b0; opcode = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cycle(0, opcode);
        end
        rst = 1'b0;
        tick(); check_cycle(0, opcode);
        tick(); check_cycle(0, opcode);

        // Directed instructions, back-to-back with run=1.
        run = 1'b1;
        tick();
        do_instr(OP_R,   1, 1'b1);
        do_instr(OP_LW,  1, 1'b1);
        do_instr(OP_SW,  1, 1'b1);
        do_instr(OP_BEQ, 1, 1'b1);
        do_instr(OP_J,   1, 1'b1);
        do_instr(6'b111111, 1, 1'b1);
        do_instr(OP_ADDI, 1, 1'b1);
        // run dropped mid-instruction: completes, then halts in IDLE.
        do_instr(OP_R,   0, 1'b0);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 5)];
            else                          op = 6'($urandom);
            do_instr(op, 2, $urandom_range(0, 3) != 0);
        end

        // Reset asserted in FETCH: write strobes forced low combinationally.
        opcode = OP_LW;
        rst = 1'b1;
        #1;
        chk("rst_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(PCWrite), 32'd0);
        chk("rst_selectins", 32'(SelectIns), 32'd1);
        tick();
        rst = 1'b0;
        cnt = 0;
        check_cycle(0, opcode);
        tick();

        // Reset asserted during MEM_RD of an LW.
        for (int k = 0; k < 4; k++) begin
            check_cycle(path_st(OP_LW, k), OP_LW);
            if (k == 3) begin
                rst = 1'b1;
                #1;
                chk("rst_memrd_regwrite", 32'(RegWrite), 32'd0);
                chk("rst_memrd_memwrite", 32'(MemWrite), 32'd0);
            end
            tick();
        end
        rst = 1'b0;
        check_cycle(0, opcode);
        chk("no_regwrite_after_rst", 32'(RegWrite), 32'd0);
        tick();

        // Five retirements from zero: narrow counter wraps through 0.
        do_instr(OP_R,    1, 1'b1);
        do_instr(OP_ADDI, 1, 1'b1);
        do_instr(OP_SW,   1, 1'b1);
        do_instr(OP_BEQ,  1, 1'b1);
        check_cycle(1, OP_J);
        chk("wrap_at_4", 32'(b_count), 32'd0);
        do_instr(OP_J,    1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
